mux_rr_pipe: RTL and testbench

//  Parametrised N-input, WIDTH-bit datapath selector with a valid/ready handshake and a one-entry registered output.

---
 rtl/mux_rr_pipe.sv | 93 +++++++++
 tb/tb_mux_rr_pipe.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_pipe.sv
// N-input selector with fixed-select or round-robin grant feeding a one-entry registered output.
// Define MUX_STALL_CNT_EN to add the saturating stall_cnt output.
module mux_rr_pipe #(
   parameter  int WIDTH  = 16,
   parameter  int NUM_IN = 4,
   localparam int SEL_W  = $clog2(NUM_IN)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_IN*WIDTH-1:0] in_data,
   input  logic [NUM_IN-1:0]       in_valid,
   output logic [NUM_IN-1:0]       in_ready,
   input  logic                    mode,
   input  logic [SEL_W-1:0]        sel,
   output logic [WIDTH-1:0]        out_data,
   output logic [SEL_W-1:0]        out_src,
   output logic                    out_valid,
   input  logic                    out_ready
`ifdef MUX_STALL_CNT_EN
   ,
   output logic [15:0]             stall_cnt
`endif
);

   logic [SEL_W-1:0]  ptr;
   logic [SEL_W-1:0]  grant;
   logic              has_grant;
   logic              load_en;
   logic              xfer;
   logic [NUM_IN-1:0] rot_valid;
   logic [WIDTH-1:0]  grant_word;

   assign load_en = !out_valid || out_ready;
   assign xfer    = load_en && has_grant;

   // rot_valid[k] is the request of channel (ptr+k) wrapped, so the first set bit is the rr winner
   always_comb begin
      grant     = '0;
      has_grant = 1'b0;
      rot_valid = NUM_IN'({in_valid, in_valid} >> ptr);
      if (!mode) begin
         for (int i = 0; i < NUM_IN; i++) begin
            if (int'(sel) == i && in_valid[i]) begin
               grant     = SEL_W'(i);
               has_grant = 1'b1;
            end
         end
      end else begin
         for (int k = 0; k < NUM_IN; k++) begin
            if (!has_grant && rot_valid[k]) begin
               has_grant = 1'b1;
               grant     = (int'(ptr) + k >= NUM_IN) ? SEL_W'(int'(ptr) + k - NUM_IN)
                                                     : SEL_W'(int'(ptr) + k);
            end
         end
      end
   end

   always_comb begin
      grant_word = '0;
      in_ready   = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         if (int'(grant) == i) grant_word = in_data[i*WIDTH +: WIDTH];
         in_ready[i] = rst_n && load_en && has_grant && (int'(grant) == i);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data  <= '0;
         out_src   <= '0;
         out_valid <= 1'b0;
         ptr       <= '0;
      end else begin
         if (xfer) begin
            out_data  <= grant_word;
            out_src   <= grant;
            out_valid <= 1'b1;
            if (mode) ptr <= (int'(grant) == NUM_IN - 1) ? '0 : grant + 1'b1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

`ifdef MUX_STALL_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) stall_cnt <= '0;
      else if (out_valid && !out_ready && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
   end
`endif

endmodule

// File: tb/tb_mux_rr_pipe.sv
// Bench for mux_rr_pipe: a 4-input and a 3-input instance driven in lockstep, checked against a
// transaction-level reference model; directed scenarios followed by a randomized run.
module tb_mux_rr_pipe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mode;
   logic [1:0]  sel;
   logic        out_ready;
   logic [15:0] w [2][4];
   logic [3:0]  v [2];

   logic [63:0] d4_data;
   logic [47:0] d3_data;
   logic [3:0]  r4;
   logic [2:0]  r3;
   logic [15:0] o4_data, o3_data;
   logic [1:0]  o4_src, o3_src;
   logic        o4_valid, o3_valid;
`ifdef MUX_STALL_CNT_EN
   logic [15:0] c4, c3;
`endif

   assign d4_data = {w[0][3], w[0][2], w[0][1], w[0][0]};
   assign d3_data = {w[1][2], w[1][1], w[1][0]};

   always #5 clk = ~clk;

   mux_rr_pipe #(.WIDTH(16), .NUM_IN(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_data(d4_data), .in_valid(v[0]), .in_ready(r4),
      .mode(mode), .sel(sel), .out_data(o4_data), .out_src(o4_src), .out_valid(o4_valid),
      .out_ready(out_ready)
`ifdef MUX_STALL_CNT_EN
      , .stall_cnt(c4)
`endif
   );

   mux_rr_pipe #(.WIDTH(16), .NUM_IN(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .in_data(d3_data), .in_valid(v[1][2:0]), .in_ready(r3),
      .mode(mode), .sel(sel), .out_data(o3_data), .out_src(o3_src), .out_valid(o3_valid),
      .out_ready(out_ready)
`ifdef MUX_STALL_CNT_EN
      , .stall_cnt(c3)
`endif
   );

   int          passes = 0;
   int          total  = 0;
   bit          m_valid [2];
   logic [15:0] m_data  [2];
   int          m_src   [2];
   int          m_ptr   [2];
   int          m_cnt   [2];
   int          lastg   [2];

   function automatic int nin(int d);
      return (d == 0) ? 4 : 3;
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      total++;
      assert (obs === exp) passes++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_valid[d] = 1'b0;
         m_data[d]  = 16'h0;
         m_src[d]   = 0;
         m_ptr[d]   = 0;
         m_cnt[d]   = 0;
         lastg[d]   = -1;
      end
   endtask

   // Which channel the rules say wins this cycle, or -1
   function automatic int pick(int d);
      int n = nin(d);
      if (!mode) return (int'(sel) < n && v[d][sel]) ? int'(sel) : -1;
      for (int k = 0; k < n; k++) begin
         int c = (m_ptr[d] + k) % n;
         if (v[d][c]) return c;
      end
      return -1;
   endfunction

   task automatic check_outs();
      chk("out_valid4", 32'(o4_valid), 32'(m_valid[0]));
      chk("out_data4",  32'(o4_data),  32'(m_data[0]));
      chk("out_src4",   32'(o4_src),   m_src[0]);
      chk("out_valid3", 32'(o3_valid), 32'(m_valid[1]));
      chk("out_data3",  32'(o3_data),  32'(m_data[1]));
      chk("out_src3",   32'(o3_src),   m_src[1]);
`ifdef MUX_STALL_CNT_EN
      chk("stall_cnt4", 32'(c4), m_cnt[0]);
      chk("stall_cnt3", 32'(c3), m_cnt[1]);
`endif
   endtask

   // Called just after a negedge with inputs already driven; returns at the next negedge
   task automatic step();
      int          g;
      logic [31:0] er;
      #1;
      for (int d = 0; d < 2; d++) begin
         g  = pick(d);
         er = ((!m_valid[d] || out_ready) && g >= 0) ? (32'd1 << g) : 32'd0;
         chk($sformatf("in_ready%0d", nin(d)), (d == 0) ? 32'(r4) : 32'(r3), er);
         lastg[d] = (er != 0) ? g : -1;
      end
      @(posedge clk);
      for (int d = 0; d < 2; d++) begin
         if (m_valid[d] && !out_ready && m_cnt[d] < 32'hFFFF) m_cnt[d]++;
         if (lastg[d] >= 0) begin
            m_valid[d] = 1'b1;
            m_data[d]  = w[d][lastg[d]];
            m_src[d]   = lastg[d];
            if (mode) m_ptr[d] = (lastg[d] + 1) % nin(d);
         end else if (out_ready) begin
            m_valid[d] = 1'b0;
         end
      end
      #1;
      check_outs();
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0; mode = 1'b0; sel = 2'd0; out_ready = 1'b1;
      for (int d = 0; d < 2; d++) begin
         v[d] = 4'h0;
         for (int c = 0; c < 4; c++) w[d][c] = 16'h0;
      end
      v[0] = 4'hF;
      model_reset();
      #2;
      check_outs();
      chk("reset_in_ready4", 32'(r4), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // fixed select of channel 2
      mode = 1'b0; sel = 2'd2; w[0][2] = 16'hBEEF;
      step();
      chk("t2_data", 32'(o4_data), 32'h0000BEEF);
      chk("t2_src",  32'(o4_src),  32'd2);

      // round-robin, all channels requesting
      mode = 1'b1;
      for (int s = 0; s < 6; s++) begin
         step();
         chk("t3_src_seq", 32'(o4_src), s % 4);
      end

      // backpressure on a held 16'h1234
      mode = 1'b0; sel = 2'd1; w[0][1] = 16'h1234;
      step();
      out_ready = 1'b0; w[0][1] = 16'h5678;
      for (int s = 0; s < 5; s++) begin
         step();
         chk("t4_hold", 32'(o4_data), 32'h1234);
      end
`ifdef MUX_STALL_CNT_EN
      chk("t4_stall5", 32'(c4), 32'd5);
`endif
      out_ready = 1'b1;
      step();
      chk("t4_reload", 32'(o4_data), 32'h5678);

      // three channels, rr with {2,0} requesting from pointer 1
      v[0] = 4'h0; mode = 1'b1;
      v[1] = 4'b0001; step();
      v[1] = 4'b0101; step();
      chk("t5_grant2", 32'(o3_src), 32'd2);
      step();
      chk("t5_wrap0", 32'(o3_src), 32'd0);
      v[1] = 4'b0111; step();
      chk("t5_ptr1", 32'(o3_src), 32'd1);

      // out-of-range select on the 3-input instance
      mode = 1'b0; sel = 2'd3; step();
      chk("t6_drained", 32'(o3_valid), 32'd0);
      chk("t6_no_x", 32'($isunknown(o3_data)), 32'd0);

      // asynchronous reset in the middle of a stall
      sel = 2'd0; v[0] = 4'hF; w[0][0] = 16'hAAAA; step();
      out_ready = 1'b0; step();
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_outs();
      chk("t1_in_ready_rst", 32'(r4), 32'd0);
      @(negedge clk);
      rst_n = 1'b1; mode = 1'b1; out_ready = 1'b1;
      step();
      chk("t1_rr_start0", 32'(o4_src), 32'd0);

      // randomized traffic; a producer only changes its offer after acceptance or while idle
      for (int t = 0; t < 400; t++) begin
         mode      = ($urandom_range(0, 9) < 7);
         sel       = 2'($urandom_range(0, 3));
         out_ready = ($urandom_range(0, 3) != 0);
         for (int d = 0; d < 2; d++)
            for (int c = 0; c < nin(d); c++)
               if (!v[d][c] || lastg[d] == c) begin
                  v[d][c] = 1'($urandom_range(0, 1));
                  w[d][c] = 16'($urandom);
               end
         step();
      end

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
